sample_serializer: RTL and testbench

Consumer end of the sample-request handshake used by the music player's tone generators. It issues one-cycle `generate_next_sample` requests at the audio frame rate and captures `sample_in` when `new_sample_ready` pulses. Each captured 16-bit sample is shifted out to the DAC as a left-justified serial stream. The same mono sample goes on both channels, framed by bit clock and LR clock outputs.

---
 rtl/sample_serializer.sv | 192 +++++++++++++++++++
 tb/tb_sample_serializer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_serializer.sv
// -----------------------------------------------------------------------------
// sample_serializer
//
// Consumer end of the tone generator sample-request handshake, feeding a
// left-justified serial DAC. The block asks the generator for one sample per
// audio frame, captures it, and shifts the same 16-bit mono sample out on both
// the left and right half-frames, MSB first.
//
// Handshake with the generator:
//   generate_next_sample is a registered one-cycle request strobe. The
//   generator answers at any later time with a one-cycle new_sample_ready
//   strobe and sample_in valid in that same cycle. A sample is consumed at
//   most once. In RUN, the newest answer before the frame reload wins. If no
//   answer arrived, the previous sample is repeated and underrun latches.
//   Requests are never retried. Disabling the block abandons any open request.
//
// Serial framing (BCLK_HALF clk cycles per bclk half-period):
//   - bclk toggles every BCLK_HALF cycles while running. A 1->0 toggle is a
//     "fall event"; sdata and lrck only change on fall events.
//   - One frame is 32 bclk periods: bits 0-15 are left (lrck=0) and bits
//     16-31 are right (lrck=1).
//   - The receiver samples on bclk rising edges.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous active-low reset
//   en                   run enable (level)
//   sample_in[15:0]      two's-complement sample, valid with new_sample_ready
//   new_sample_ready     one-cycle strobe from the generator
//   generate_next_sample one-cycle request strobe to the generator
//   bclk                 serial bit clock
//   lrck                 0 = left half-frame, 1 = right half-frame
//   sdata                serial data, MSB first
//   underrun             sticky: a frame started without a fresh sample
//   fsm_state[1:0]       debug view of the controller state
//                        (0 = IDLE, 1 = PRIME, 2 = RUN)
// -----------------------------------------------------------------------------
module sample_serializer #(
  parameter int BCLK_HALF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] sample_in,
  input  logic        new_sample_ready,
  output logic        generate_next_sample,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        underrun,
  output logic [1:0]  fsm_state
);

  // The divider only has to hold 0..BCLK_HALF-1. Keep at least one bit so a
  // degenerate parameter still elaborates.
  localparam int               DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [4:0]        bit_cnt;
  logic [31:0]       shreg;
  logic [15:0]       hold;
  logic              hold_valid;

  logic              div_wrap;
  logic              fall_evt;
  logic [4:0]        bit_next;

  // bclk toggles on the wrap cycle. The toggle is a fall event when bclk is
  // currently high.
  assign div_wrap  = (div_cnt == DIV_LAST);
  assign fall_evt  = div_wrap & bclk;
  // The 5-bit counter wraps 31 -> 0 naturally at the frame boundary.
  assign bit_next  = bit_cnt + 5'd1;

  // shreg is cleared whenever the block is not running, so sdata is 0 there.
  assign sdata     = shreg[31];
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      div_cnt              <= '0;
      bit_cnt              <= 5'd0;
      shreg                <= 32'd0;
      hold                 <= 16'd0;
      hold_valid           <= 1'b0;
      bclk                 <= 1'b0;
      lrck                 <= 1'b0;
      underrun             <= 1'b0;
      generate_next_sample <= 1'b0;
    end else begin
      // The request strobe is a single-cycle pulse unless set again below.
      generate_next_sample <= 1'b0;

      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= 5'd0;
          bclk    <= 1'b0;
          lrck    <= 1'b0;
          shreg   <= 32'd0;
          // Generator strobes are ignored here. The PRIME exchange fully
          // reloads hold and hold_valid before they are used again.
          if (en) begin
            state                <= PRIME;
            generate_next_sample <= 1'b1;
          end
        end

        PRIME: begin
          if (!en) begin
            state <= IDLE;
          end else if (new_sample_ready) begin
            // The primed sample goes straight into the shifter for frame 0.
            // hold keeps a copy so that an unanswered first-frame request
            // repeats it. hold_valid stays 0 because the copy has already
            // been consumed.
            hold       <= sample_in;
            shreg      <= {sample_in, sample_in};
            hold_valid <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= 5'd0;
            bclk       <= 1'b0;
            lrck       <= 1'b0;
            state      <= RUN;
          end
        end

        RUN: begin
          if (!en) begin
            // Disable beats a simultaneous fall event: no shift, no request.
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= 5'd0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
            shreg   <= 32'd0;
          end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap) begin
              bclk <= ~bclk;
            end

            if (fall_evt) begin
              bit_cnt <= bit_next;
              lrck    <= bit_next[4];

              if (bit_cnt == 5'd31) begin
                // Frame boundary: load the next sample for both channels.
                // Without a fresh answer the old hold is replayed.
                shreg <= {hold, hold};
                if (!hold_valid) begin
                  underrun <= 1'b1;
                end
                hold_valid <= 1'b0;
              end else begin
                shreg <= {shreg[30:0], 1'b0};
              end

              // The request goes out at mid-frame. This gives the generator
              // just under half a frame before the reload.
              if (bit_cnt == 5'd15) begin
                generate_next_sample <= 1'b1;
              end
            end

            // This capture comes after the reload code, so a strobe that
            // coincides with the reload fall event sets hold_valid for the
            // following frame. It does not feed the reload in progress.
            if (new_sample_ready) begin
              hold       <= sample_in;
              hold_valid <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// -----------------------------------------------------------------------------
// tb_sample_serializer
//
// Directed bench for sample_serializer with BCLK_HALF = 4 (256-cycle frames).
//   - A generator process answers each request one cycle later with the next
//     entry of its script. One entry is scripted as "no answer".
//   - The stimulus process drives reset and en, and injects a stray strobe
//     while the block is idle.
//   - A single monitor process runs on every falling clk edge. It:
//       * predicts all outputs from a time-based frame model and compares
//         them with the DUT;
//       * acts as the DAC receiver, collecting sdata on bclk rises and
//         checking each complete frame against hand-written words;
//       * checks lrck against the bit position;
//       * at the end, checks the request count and spacing;
//       * prints the summary line.
// -----------------------------------------------------------------------------
module tb_sample_serializer;

  localparam int H          = 4;
  localparam int FRAME      = 64 * H;   // clk cycles per frame
  localparam int HALF_FRAME = 32 * H;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] sample_in;
  logic        new_sample_ready;
  logic        generate_next_sample;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        underrun;
  logic [1:0]  fsm_state;

  // Generator-driven and stimulus-driven (stray) strobes are merged here.
  logic        gen_nsr;
  logic [15:0] gen_sample;
  logic        stray_nsr;
  logic [15:0] stray_sample;
  assign new_sample_ready = gen_nsr | stray_nsr;
  assign sample_in        = stray_nsr ? stray_sample : gen_sample;

  logic probe_under;
  logic done;

  sample_serializer #(.BCLK_HALF(H)) dut (
    .clk                  (clk),
    .reset                (reset),
    .en                   (en),
    .sample_in            (sample_in),
    .new_sample_ready     (new_sample_ready),
    .generate_next_sample (generate_next_sample),
    .bclk                 (bclk),
    .lrck                 (lrck),
    .sdata                (sdata),
    .underrun             (underrun),
    .fsm_state            (fsm_state)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ------------------------------------------------------------ generator
  // Script entries are {answer, sample}. answer=0 means the request is
  // silently dropped.
  logic [16:0] gen_q[$];

  initial begin : generator
    logic [16:0] e;
    gen_nsr    = 1'b0;
    gen_sample = 16'd0;
    gen_q = {17'h1A5C3, 17'h10001, 17'h18000, 17'h17FFF, 17'h1FFFF,
             17'h00000, 17'h11357, 17'h12468, 17'h15A5A,
             17'h1BEEF, 17'h14321};
    forever begin
      @(negedge clk);
      if (reset && generate_next_sample) begin
        @(posedge clk);
        #1;
        if (gen_q.size() > 0) e = gen_q.pop_front();
        else                  e = 17'h10F0F;
        if (e[16]) begin
          gen_nsr    = 1'b1;
          gen_sample = e[15:0];
        end
        @(posedge clk);
        #1;
        gen_nsr = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin : stimulus
    reset        = 1'b0;
    en           = 1'b0;
    stray_nsr    = 1'b0;
    stray_sample = 16'd0;
    probe_under  = 1'b0;
    done         = 1'b0;

    // Reset, then 1000 idle cycles with en low.
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (1000) @(posedge clk);

    // Enable. PRIME, then RUN begins 3 cycles later at t=0.
    #1 en = 1'b1;
    // Drop en during RUN cycle t=1958 (bit_cnt = 20 in frame 7).
    repeat (1961) @(posedge clk);
    #1 en = 1'b0;

    // A late strobe while idle must be ignored.
    repeat (6) @(posedge clk);
    #1 stray_nsr = 1'b1;
    stray_sample = 16'hDEAD;
    @(posedge clk);
    #1 stray_nsr = 1'b0;

    // Re-enable: fresh PRIME request, then one full frame.
    repeat (6) @(posedge clk);
    #1 en = 1'b1;
    repeat (303) @(posedge clk);
    #1 probe_under = 1'b1;
    @(posedge clk);
    #1 probe_under = 1'b0;
    // Asynchronous reset between clock edges, in the middle of RUN.
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1 done = 1'b1;
  end

  // ------------------------------------------------------------- monitor
  int          n_checks;
  int          n_errors;
  int          cyc;
  logic [31:0] exp_q[$];
  int          req_q[$];

  // Frame model state
  int          m_mode;      // 0 idle, 1 prime, 2 run
  bit          m_first;
  int          m_t;         // cycles since RUN entry
  logic [15:0] m_cur;
  logic [15:0] m_pend;
  bit          m_pend_v;
  bit          m_under;

  // Receiver state
  logic        prev_bclk;
  int          rx_n;
  logic [31:0] rx_word;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    logic [4:0]  e_out;
    logic [4:0]  a_out;
    logic [31:0] w;
    int          f;
    int          b;
    bit          e_gen;
    bit          e_bclk;
    bit          e_lrck;
    bit          e_sdata;

    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    m_mode    = 0;
    m_first   = 0;
    m_t       = 0;
    m_cur     = 16'd0;
    m_pend    = 16'd0;
    m_pend_v  = 0;
    m_under   = 0;
    prev_bclk = 1'b0;
    rx_n      = 0;
    rx_word   = 32'd0;

    // Hand-written frame words, in the order they must appear on the wire.
    exp_q = {32'hA5C3A5C3, 32'h00010001, 32'h80008000, 32'h7FFF7FFF,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h13571357, 32'hBEEFBEEF};

    forever begin
      @(negedge clk);
      if (done) break;
      cyc++;

      // ---- predicted outputs for this cycle
      e_gen = 0; e_bclk = 0; e_lrck = 0; e_sdata = 0;
      if (reset) begin
        if (m_mode == 1) begin
          e_gen = m_first;
        end else if (m_mode == 2) begin
          f       = m_t / (2 * H);
          b       = f % 32;
          e_bclk  = ((m_t / H) % 2) == 1;
          e_lrck  = b >= 16;
          e_sdata = m_cur[15 - (b % 16)];
          e_gen   = (m_t >= HALF_FRAME) && (((m_t - HALF_FRAME) % FRAME) == 0);
        end
      end
      e_out = {e_gen, e_bclk, e_lrck, e_sdata, (reset ? m_under : 1'b0)};
      a_out = {generate_next_sample, bclk, lrck, sdata, underrun};
      check("outputs{gen,bclk,lrck,sdata,underrun}", {27'd0, a_out}, {27'd0, e_out});

      if (probe_under) check("underrun_sticky", {31'd0, underrun}, 32'd1);

      if (reset && generate_next_sample) req_q.push_back(cyc);

      // ---- receiver: collect bits on bclk rises while running
      if (!reset || m_mode != 2) begin
        rx_n = 0;
      end else if (bclk && !prev_bclk) begin
        check("lrck_at_rise", {31'd0, lrck}, {31'd0, (rx_n >= 16)});
        rx_word = {rx_word[30:0], sdata};
        rx_n++;
        if (rx_n == 32) begin
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("frame_word", rx_word, w);
          end
          rx_n = 0;
        end
      end
      prev_bclk = bclk;

      // ---- advance the model with this cycle's inputs
      if (!reset) begin
        m_mode   = 0;
        m_first  = 0;
        m_under  = 0;
        m_pend_v = 0;
      end else begin
        case (m_mode)
          0: if (en) begin
               m_mode  = 1;
               m_first = 1;
             end
          1: begin
               m_first = 0;
               if (!en) begin
                 m_mode = 0;
               end else if (new_sample_ready) begin
                 m_mode   = 2;
                 m_t      = 0;
                 m_cur    = sample_in;
                 m_pend_v = 0;
               end
             end
          default: begin
               if (!en) begin
                 m_mode = 0;
               end else begin
                 // Last cycle of a frame: the next frame's sample is decided
                 // before this cycle's strobe is taken into account.
                 if ((m_t % FRAME) == FRAME - 1) begin
                   if (m_pend_v) m_cur = m_pend;
                   else          m_under = 1;
                   m_pend_v = 0;
                 end
                 if (new_sample_ready) begin
                   m_pend   = sample_in;
                   m_pend_v = 1;
                 end
                 m_t++;
               end
             end
        endcase
      end
    end

    // ---- end-of-run checks
    check("frames_outstanding", exp_q.size(), 32'd0);
    check("request_count", req_q.size(), 32'd11);
    if (req_q.size() == 11) begin
      check("prime_to_first_run_request", req_q[1] - req_q[0], 32'd130);
      for (int k = 1; k < 8; k++) begin
        check("run_request_spacing", req_q[k + 1] - req_q[k], FRAME);
      end
      check("reprime_to_run_request", req_q[10] - req_q[9], 32'd130);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
